chaos_sync_receiver: RTL

CHAOS_SYNC_RECEIVER -- requirements
Module: chaos_sync_receiver

---
 rtl/chaos_sync_pkg.sv | 25 ++
 rtl/sat_counter16.sv | 31 +++
 rtl/chaos_sync_receiver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/chaos_sync_pkg.sv
// rtl/chaos_sync_pkg.sv - shared types, marker default and header check rule for the chaos sync receiver
package chaos_sync_pkg;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_GET_STATE = 2'd1,
        ST_GET_CHECK = 2'd2,
        ST_PAYLOAD   = 2'd3
    } rx_state_e;

    localparam logic [31:0] DEFAULT_SYNC_MARKER = 32'hA5C3_5A3C;

    // Widest word the check helper handles; narrower words are zero-extended and masked.
    localparam int CHECK_MAX_W = 64;

    // The header check word must be the bitwise inverse of the state word.
    function automatic logic check_matches(
        input logic [CHECK_MAX_W-1:0] word,
        input logic [CHECK_MAX_W-1:0] state,
        input logic [CHECK_MAX_W-1:0] mask
    );
        return ((word ^ ~state) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit event counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_d;
    logic [15:0] count_q;

    // Next count: step on inc unless already pinned at the top.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/chaos_sync_receiver.sv
// rtl/chaos_sync_receiver.sv - frame hunter and payload decryptor locked to an external chaotic keystream
module chaos_sync_receiver
    import chaos_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    PAYLOAD_WORDS = 64,
    parameter logic [DATA_WIDTH-1:0] SYNC_MARKER   = DATA_WIDTH'(DEFAULT_SYNC_MARKER)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] key_in,
    output logic                  sync_en,
    output logic [DATA_WIDTH-1:0] sync_state,
    output logic                  next_key_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  locked,
    output logic                  check_error,
    output logic [15:0]           frames_ok,
    output logic [15:0]           sync_errors
);

    localparam int CNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_WORDS - 1);
    localparam logic [CHECK_MAX_W-1:0] WORD_MASK = {CHECK_MAX_W{1'b1}} >> (CHECK_MAX_W - DATA_WIDTH);

    rx_state_e             state_d, state_q;
    logic [DATA_WIDTH-1:0] sync_state_d, sync_state_q;
    logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
    logic                  out_valid_d, out_valid_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  check_error_d, check_error_q;
    logic                  sync_pulse, key_pulse;
    logic                  frame_done, hdr_error;
    logic                  accept;

    // Payload stalls only when an undrained output word would be overwritten.
    assign in_ready = (state_q != ST_PAYLOAD) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state, capture and pulse decode for the frame FSM.
    always_comb begin
        state_d       = state_q;
        sync_state_d  = sync_state_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q && !out_ready;
        cnt_d         = cnt_q;
        check_error_d = 1'b0;
        sync_pulse    = 1'b0;
        key_pulse     = 1'b0;
        frame_done    = 1'b0;
        hdr_error     = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (accept && (in_data == SYNC_MARKER)) begin
                    state_d = ST_GET_STATE;
                end
            end
            ST_GET_STATE: begin
                if (accept) begin
                    sync_state_d = in_data;
                    state_d      = ST_GET_CHECK;
                end
            end
            ST_GET_CHECK: begin
                if (accept) begin
                    if (check_matches(CHECK_MAX_W'(in_data), CHECK_MAX_W'(sync_state_q), WORD_MASK)) begin
                        sync_pulse = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        check_error_d = 1'b1;
                        hdr_error     = 1'b1;
                        state_d       = (in_data == SYNC_MARKER) ? ST_GET_STATE : ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    out_data_d  = in_data ^ key_in;
                    out_valid_d = 1'b1;
                    key_pulse   = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = '0;
                        frame_done = 1'b1;
                        state_d    = ST_HUNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Frame FSM and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            sync_state_q  <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            cnt_q         <= '0;
            check_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_state_q  <= sync_state_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            cnt_q         <= cnt_d;
            check_error_q <= check_error_d;
        end
    end

    // The generator steps one cycle after these pulses, so they must fire in the
    // acceptance cycle itself; a registered copy would let back-to-back payload
    // words see a stale key.
    assign sync_en     = sync_pulse && !rst;
    assign next_key_en = key_pulse && !rst;

    assign sync_state  = sync_state_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign locked      = (state_q == ST_PAYLOAD);
    assign check_error = check_error_q;

    sat_counter16 u_frames_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_done),
        .count (frames_ok)
    );

    sat_counter16 u_sync_errors (
        .clk   (clk),
        .rst   (rst),
        .inc   (hdr_error),
        .count (sync_errors)
    );

endmodule
